// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: state encoding, requester ids and
// the limits that size the read-latency counter.
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Requester ids (bit position in req/gnt/done)
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Largest supported RAM read latency and the counter width it needs
  localparam int RAM_LAT_MAX = 7;
  localparam int LAT_CNT_W   = $clog2(RAM_LAT_MAX + 1);

  // Expand a requester id into its one-hot strobe position
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the RAM arbiter. The requesters (CPU memory path and
// loader/DMA port) drive the master side, the arbiter sits on the slave side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, done, rdata0, rdata1, busy
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, done, rdata0, rdata1, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Two-way round-robin pick. A lone request wins outright; when both are
// pending the requester that was not served last time wins.
module rr_select
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_winner,
  output logic       o_any
);

  // Choose the winner from the pending requests and the last grant
  always_comb begin
    o_any    = |i_req;
    o_winner = REQ_CPU;
    if (i_req == 2'b11) begin
      o_winner = ~i_last_gnt;
    end else if (i_req[REQ_LDR]) begin
      o_winner = REQ_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port RAM between the CPU memory path
// (requester 0) and the program loader / DMA port (requester 1).
// One access in flight: IDLE -> ACCESS -> WAIT (RAM_LAT cycles) -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_write,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  // Value loaded into the latency down-counter when WAIT is entered
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RAM_LAT - 1);

  logic [1:0]           r_state;
  logic                 r_winner;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_last_gnt;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]    r_rdata0;
  logic [DATA_W-1:0]    r_rdata1;

  logic                 w_winner;
  logic                 w_any;
  logic                 w_last_wait;

  rr_select u_rr_select (
    .i_req      (bus.req),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_any      (w_any)
  );

  assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == '0);

  // Sequencer: sample requests in IDLE, latch the winner's access, count out the RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_winner   <= REQ_CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_last_gnt <= REQ_LDR;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_winner <= w_winner;
            r_we     <= bus.we[w_winner];
            r_addr   <= w_winner ? bus.addr1 : bus.addr0;
            r_wdata  <= w_winner ? bus.wdata1 : bus.wdata0;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_cnt   <= LAT_LOAD;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_last_gnt <= r_winner;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture RAM read data into the winner's register at the end of the last WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_last_wait && !r_we) begin
      if (r_winner == REQ_LDR) begin
        r_rdata1 <= i_ram_rdata;
      end else begin
        r_rdata0 <= i_ram_rdata;
      end
    end
  end

  // Strobes are decoded from the state so an async reset clears them at once
  assign bus.gnt     = (r_state == ST_ACCESS) ? id_to_onehot(r_winner) : 2'b00;
  assign bus.done    = (r_state == ST_RESP)   ? id_to_onehot(r_winner) : 2'b00;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_ram_write = (r_state == ST_ACCESS) && r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with RAM_LAT=1 and one with RAM_LAT=3,
// each in front of a small RAM model with the matching read latency.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus1 ();
  mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus3 ();

  logic [8:0]  ramAddr1;
  logic [31:0] ramWdata1;
  logic        ramWrite1;
  logic [31:0] ramRdata1;

  logic [8:0]  ramAddr3;
  logic [31:0] ramWdata3;
  logic        ramWrite3;
  logic [31:0] ramRdata3;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus1),
    .o_ram_addr  (ramAddr1),
    .o_ram_wdata (ramWdata1),
    .o_ram_write (ramWrite1),
    .i_ram_rdata (ramRdata1)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus3),
    .o_ram_addr  (ramAddr3),
    .o_ram_wdata (ramWdata3),
    .o_ram_write (ramWrite3),
    .i_ram_rdata (ramRdata3)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of a never-written RAM word: a marker word at 0x010, inverted address elsewhere
  function automatic logic [31:0] ramDefault(input logic [8:0] a);
    return (a == 9'h010) ? 32'hDEADBEEF : ~{23'd0, a};
  endfunction

  // Single-cycle-latency RAM behind dut1
  logic [31:0] mem1 [512];
  bit          val1 [512] = '{default: 1'b0};
  always @(posedge clk) begin
    if (ramWrite1) begin
      mem1[ramAddr1] <= ramWdata1;
      val1[ramAddr1] <= 1'b1;
    end
    ramRdata1 <= val1[ramAddr1] ? mem1[ramAddr1] : ramDefault(ramAddr1);
  end

  // Three-cycle-latency read-only RAM behind dut3
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe3[0] <= ramDefault(ramAddr3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ramRdata3 = pipe3[2];

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the requester side of dut1
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                               input logic [8:0] a0, input logic [8:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    bus1.req    = req;
    bus1.we     = we;
    bus1.addr0  = a0;
    bus1.addr1  = a1;
    bus1.wdata0 = d0;
    bus1.wdata1 = d1;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // gnt and done must never overlap and each must be at most one-hot
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("strobe_invariant",
                  {31'd0, ((bus1.gnt & {2{|bus1.done}}) == 2'b00) && $onehot0(bus1.gnt) && $onehot0(bus1.done)},
                  32'd1);
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held with requests active on both ports
    rst_n = 1'b0;
    applyStimulus(2'b11, 2'b11, 9'h055, 9'h066, 32'hAAAA5555, 32'h5555AAAA);
    bus3.req = 2'b11; bus3.we = 2'b11; bus3.addr0 = 9'h055; bus3.addr1 = 9'h066;
    bus3.wdata0 = 32'h1; bus3.wdata1 = 32'h2;
    repeat (3) nextCycle();
    checkOutput("rst_gnt",       {30'd0, bus1.gnt},  32'd0);
    checkOutput("rst_done",      {30'd0, bus1.done}, 32'd0);
    checkOutput("rst_busy",      {31'd0, bus1.busy}, 32'd0);
    checkOutput("rst_ram_write", {31'd0, ramWrite1}, 32'd0);
    checkOutput("rst_ram_addr",  {23'd0, ramAddr1},  32'd0);
    checkOutput("rst_ram_wdata", ramWdata1,          32'd0);
    checkOutput("rst_rdata0",    bus1.rdata0,        32'd0);
    checkOutput("rst_rdata1",    bus1.rdata1,        32'd0);
    checkOutput("rst_busy_lat3", {31'd0, bus3.busy}, 32'd0);

    // CPU read of 0x010 straight after reset release
    applyStimulus(2'b01, 2'b00, 9'h010, 9'h000, 32'd0, 32'd0);
    bus3.req = 2'b00; bus3.we = 2'b00;
    rst_n = 1'b1;
    nextCycle();
    checkOutput("t1_gnt",       {30'd0, bus1.gnt},  32'h1);
    checkOutput("t1_ram_addr",  {23'd0, ramAddr1},  32'h010);
    checkOutput("t1_ram_write", {31'd0, ramWrite1}, 32'd0);
    checkOutput("t1_busy",      {31'd0, bus1.busy}, 32'd1);
    bus1.req = 2'b00;
    nextCycle();
    checkOutput("t1_wait_done", {30'd0, bus1.done}, 32'd0);
    nextCycle();
    checkOutput("t1_done",      {30'd0, bus1.done}, 32'h1);
    checkOutput("t1_rdata0",    bus1.rdata0,        32'hDEADBEEF);
    nextCycle();
    checkOutput("t1_idle_busy", {31'd0, bus1.busy}, 32'd0);

    // Loader write 0x12345678 to 0x1FF, then CPU reads it back
    applyStimulus(2'b10, 2'b10, 9'h000, 9'h1FF, 32'd0, 32'h12345678);
    nextCycle();
    checkOutput("t2_gnt",       {30'd0, bus1.gnt},  32'h2);
    checkOutput("t2_ram_write", {31'd0, ramWrite1}, 32'd1);
    checkOutput("t2_ram_addr",  {23'd0, ramAddr1},  32'h1FF);
    checkOutput("t2_ram_wdata", ramWdata1,          32'h12345678);
    applyStimulus(2'b00, 2'b00, 9'h000, 9'h000, 32'd0, 32'd0);
    nextCycle();
    checkOutput("t2_write_drop", {31'd0, ramWrite1}, 32'd0);
    checkOutput("t2_addr_held",  {23'd0, ramAddr1},  32'h1FF);
    nextCycle();
    checkOutput("t2_done",       {30'd0, bus1.done}, 32'h2);
    checkOutput("t2_rdata1",     bus1.rdata1,        32'd0);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 9'h1FF, 9'h000, 32'd0, 32'd0);
    nextCycle();
    checkOutput("t2_rb_gnt",   {30'd0, bus1.gnt},  32'h1);
    checkOutput("t2_rb_write", {31'd0, ramWrite1}, 32'd0);
    bus1.req = 2'b00;
    nextCycle();
    nextCycle();
    checkOutput("t2_rb_done",   {30'd0, bus1.done}, 32'h1);
    checkOutput("t2_rb_rdata0", bus1.rdata0,        32'h12345678);
    nextCycle();

    // Both requesters held continuously after a reset pulse: CPU, LDR, CPU, LDR
    rst_n = 1'b0;
    applyStimulus(2'b11, 2'b00, 9'h010, 9'h1FF, 32'd0, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("t3_gnt", {30'd0, bus1.gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput("t3_ram_write", {31'd0, ramWrite1}, 32'd0);
      nextCycle();
      checkOutput("t3_wait_gnt", {30'd0, bus1.gnt}, 32'd0);
      nextCycle();
      checkOutput("t3_done", {30'd0, bus1.done}, (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i % 2 == 0) checkOutput("t3_rdata0", bus1.rdata0, 32'hDEADBEEF);
      else            checkOutput("t3_rdata1", bus1.rdata1, 32'h12345678);
      nextCycle();
      checkOutput("t3_idle_busy", {31'd0, bus1.busy}, 32'd0);
    end
    bus1.req = 2'b00;

    // RAM_LAT=3 instance: CPU read of 0x0A5 returns ~addr with done five cycles after the sample edge
    bus3.req = 2'b01; bus3.we = 2'b00; bus3.addr0 = 9'h0A5;
    nextCycle();
    checkOutput("t4_gnt",      {30'd0, bus3.gnt},  32'h1);
    checkOutput("t4_ram_addr", {23'd0, ramAddr3},  32'h0A5);
    checkOutput("t4_write",    {31'd0, ramWrite3}, 32'd0);
    bus3.req = 2'b00;
    nextCycle();
    checkOutput("t4_done_k2", {30'd0, bus3.done}, 32'd0);
    nextCycle();
    checkOutput("t4_done_k3", {30'd0, bus3.done}, 32'd0);
    nextCycle();
    checkOutput("t4_done_k4", {30'd0, bus3.done}, 32'd0);
    checkOutput("t4_busy_k4", {31'd0, bus3.busy}, 32'd1);
    nextCycle();
    checkOutput("t4_done_k5", {30'd0, bus3.done}, 32'h1);
    checkOutput("t4_rdata0",  bus3.rdata0,        32'hFFFFFF5A);
    nextCycle();
    checkOutput("t4_idle",    {31'd0, bus3.busy}, 32'd0);

    // CPU inputs wander while a loader write is in flight; the IDLE-cycle values are used
    applyStimulus(2'b10, 2'b10, 9'h000, 9'h020, 32'd0, 32'hCAFEF00D);
    nextCycle();
    checkOutput("t6_ldr_gnt",   {30'd0, bus1.gnt},  32'h2);
    checkOutput("t6_ldr_write", {31'd0, ramWrite1}, 32'd1);
    applyStimulus(2'b01, 2'b01, 9'h033, 9'h000, 32'h0BADBAD0, 32'd0);
    nextCycle();
    bus1.addr0 = 9'h044; bus1.we = 2'b00;
    nextCycle();
    checkOutput("t6_ldr_done", {30'd0, bus1.done}, 32'h2);
    bus1.addr0 = 9'h010; bus1.we = 2'b00;
    nextCycle();
    checkOutput("t6_idle_busy", {31'd0, bus1.busy}, 32'd0);
    nextCycle();
    checkOutput("t6_cpu_gnt",   {30'd0, bus1.gnt},  32'h1);
    checkOutput("t6_cpu_addr",  {23'd0, ramAddr1},  32'h010);
    checkOutput("t6_cpu_write", {31'd0, ramWrite1}, 32'd0);
    bus1.req = 2'b00; bus1.addr0 = 9'h1FF; bus1.we = 2'b01;
    nextCycle();
    checkOutput("t6_addr_held", {23'd0, ramAddr1},  32'h010);
    checkOutput("t6_no_write",  {31'd0, ramWrite1}, 32'd0);
    nextCycle();
    checkOutput("t6_cpu_done", {30'd0, bus1.done}, 32'h1);
    checkOutput("t6_rdata0",   bus1.rdata0,        32'hDEADBEEF);
    nextCycle();
    bus1.we = 2'b00;

    // Reset during the WAIT of a loader read abandons it; CPU then wins the first tie
    applyStimulus(2'b10, 2'b00, 9'h000, 9'h010, 32'd0, 32'd0);
    nextCycle();
    checkOutput("t5_gnt", {30'd0, bus1.gnt}, 32'h2);
    bus1.req = 2'b00;
    nextCycle();
    checkOutput("t5_wait_busy", {31'd0, bus1.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy",   {31'd0, bus1.busy}, 32'd0);
    checkOutput("t5_rst_write",  {31'd0, ramWrite1}, 32'd0);
    checkOutput("t5_rst_done",   {30'd0, bus1.done}, 32'd0);
    checkOutput("t5_rst_rdata1", bus1.rdata1,        32'd0);
    applyStimulus(2'b11, 2'b00, 9'h010, 9'h1FF, 32'd0, 32'd0);
    nextCycle();
    checkOutput("t5_no_done", {30'd0, bus1.done}, 32'd0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("t5_tie_gnt", {30'd0, bus1.gnt}, 32'h1);
    bus1.req = 2'b00;
    nextCycle();
    nextCycle();
    checkOutput("t5_done",   {30'd0, bus1.done}, 32'h1);
    checkOutput("t5_rdata0", bus1.rdata0,        32'hDEADBEEF);
    checkOutput("t5_rdata1", bus1.rdata1,        32'd0);
    nextCycle();
    checkOutput("t5_idle",   {31'd0, bus1.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
